// File: rtl/mem_stage_if.sv
// Pipeline handshake bundle around the MEM stage: the EXE->MEM bus and the MEM->WB bus.
// The master modport is the MEM stage itself; slave is the surrounding pipeline.
interface mem_stage_if #(
    parameter int ES_BUS_W = 76,
    parameter int MS_BUS_W = 70
);
    logic                es_to_ms_valid;
    logic [ES_BUS_W-1:0] es_to_ms_bus;
    logic                ms_allowin;
    logic                ms_to_ws_valid;
    logic [MS_BUS_W-1:0] ms_to_ws_bus;
    logic                ws_allowin;

    modport master (
        input  es_to_ms_valid, es_to_ms_bus, ws_allowin,
        output ms_allowin, ms_to_ws_valid, ms_to_ws_bus
    );

    modport slave (
        output es_to_ms_valid, es_to_ms_bus, ws_allowin,
        input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus
    );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: waits for the data-SRAM load response, extracts and
// extends sub-word load data, and forwards {gr_we,dest,final_result,pc} to WB.
module mem_stage #(
    parameter int ES_BUS_W = 76,
    parameter int MS_BUS_W = 70
) (
    input  logic        clk,
    input  logic        reset,
    mem_stage_if.master p,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,
    output logic [37:0] ms_fwd_bus,
    output logic        ms_load_pending
);
    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ALU   = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]          state_reg, state_next;
    logic [ES_BUS_W-1:0] bus_reg;
    logic [31:0]         rbuf_reg;

    logic        ms_valid, ready_go, accept, leave;
    logic [2:0]  ld_op;
    logic [1:0]  addr_lo;
    logic        res_from_mem, gr_we;
    logic [4:0]  dest;
    logic [31:0] result, pc;
    logic [31:0] raw, extracted, final_result;
    logic [7:0]  lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign ld_op        = bus_reg[75:73];
    assign addr_lo      = bus_reg[72:71];
    assign res_from_mem = bus_reg[70];
    assign gr_we        = bus_reg[69];
    assign dest         = bus_reg[68:64];
    assign result       = bus_reg[63:32];
    assign pc           = bus_reg[31:0];

    assign ms_valid = (state_reg != S_EMPTY);
    // data_ok releases a waiting load in the same cycle it arrives.
    assign ready_go = (state_reg != S_WAIT) | data_sram_data_ok;
    assign leave    = ms_valid & ready_go & p.ws_allowin;
    assign accept   = p.es_to_ms_valid & p.ms_allowin;

    assign p.ms_allowin     = ~ms_valid | (ready_go & p.ws_allowin);
    assign p.ms_to_ws_valid = ms_valid & ready_go;

    always_comb begin
        state_next = state_reg;
        if (accept) begin
            state_next = p.es_to_ms_bus[70] ? S_WAIT : S_ALU;
        end else if (leave) begin
            state_next = S_EMPTY;
        end else if (state_reg == S_WAIT && data_sram_data_ok) begin
            state_next = S_DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_EMPTY;
            bus_reg   <= '0;
            rbuf_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                bus_reg <= p.es_to_ms_bus;
            end
            // WB stalled while data arrives: keep the word since the SRAM will not repeat it.
            if (state_reg == S_WAIT && data_sram_data_ok && !p.ws_allowin) begin
                rbuf_reg <= data_sram_rdata;
            end
        end
    end

    assign raw = (state_reg == S_DONE) ? rbuf_reg : data_sram_rdata;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane[gi] = raw[gi*8 +: 8];
    end

    assign byte_sel = lane[addr_lo];
    assign half_sel = addr_lo[1] ? raw[31:16] : raw[15:0];

    always_comb begin
        extracted = raw;
        case (ld_op)
            3'b001:  extracted = {{24{byte_sel[7]}}, byte_sel};
            3'b010:  extracted = {{16{half_sel[15]}}, half_sel};
            3'b011:  extracted = {24'b0, byte_sel};
            3'b100:  extracted = {16'b0, half_sel};
            default: extracted = raw;
        endcase
    end

    assign final_result = res_from_mem ? extracted : result;

    assign p.ms_to_ws_bus   = MS_BUS_W'({gr_we, dest, final_result, pc});
    assign ms_fwd_bus       = {ms_valid & gr_we & ready_go, dest, final_result};
    assign ms_load_pending  = ms_valid & res_from_mem & ~ready_go;
endmodule
